// File: rtl/solver_output_decimator.sv
// Solver output decimator: windowed sample/mean reduction feeding a
// first-word fall-through result FIFO with sticky overflow.
module solver_output_decimator #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [3:0]                 decim_log2,
  input  logic                       avg_en,
  input  logic signed [DATA_W-1:0]   in_data,
  input  logic                       in_valid,
  input  logic                       rd_en,
  input  logic                       flush,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ACC_W = DATA_W + 15;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state;
  logic [15:0]              cnt;
  logic signed [ACC_W-1:0]  acc;
  logic [3:0]               lg_q;
  logic                     avg_q;
  logic                     res_v;
  logic [DATA_W-1:0]        res_d;

  logic                     first;
  logic [3:0]               lg_eff;
  logic                     avg_eff;
  logic signed [ACC_W-1:0]  sum;
  logic [16:0]              cnt_nx;
  logic                     last;
  logic [DATA_W-1:0]        result;

  // Window parameters come straight from the ports on a window's first sample.
  assign first   = (state == IDLE) || (cnt == 16'd0);
  assign lg_eff  = first ? decim_log2 : lg_q;
  assign avg_eff = first ? avg_en : avg_q;
  assign sum     = acc + {{15{in_data[DATA_W-1]}}, in_data};
  assign cnt_nx  = {1'b0, cnt} + 17'd1;
  assign last    = (cnt_nx == (17'd1 << lg_eff));
  assign result  = avg_eff ? DATA_W'(sum >>> lg_eff) : in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      lg_q  <= '0;
      avg_q <= 1'b0;
      res_v <= 1'b0;
      res_d <= '0;
    end else begin
      res_v <= 1'b0;
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
        acc   <= '0;
      end else begin
        state <= ACCUM;
        if (in_valid) begin
          if (first) begin
            lg_q  <= decim_log2;
            avg_q <= avg_en;
          end
          if (last) begin
            cnt   <= '0;
            acc   <= '0;
            res_v <= 1'b1;
            res_d <= result;
          end else begin
            cnt <= cnt_nx[15:0];
            acc <= sum;
          end
        end
      end
    end
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt_f;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              we;

  assign empty = (cnt_f == '0);
  assign full  = (cnt_f == FULL);
  assign pop   = rd_en && !empty;
  // A full FIFO still accepts a result when the head leaves the same cycle.
  assign push  = res_v && (!full || pop);
  assign we    = push && !flush && rst_n;

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= res_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_f    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_f    <= '0;
      overflow <= 1'b0;
    end else begin
      if (res_v && full && !pop) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_f <= cnt_f + 1'b1;
        2'b01:   cnt_f <= cnt_f - 1'b1;
        default: cnt_f <= cnt_f;
      endcase
    end
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem[rd_ptr];
  assign fifo_count = cnt_f;

endmodule

// File: tb/tb_solver_output_decimator.sv
// Bench for solver_output_decimator: queue-based window/FIFO model compared
// every cycle, plus literal expectations for the directed scenarios.
module tb_solver_output_decimator;

  localparam int DW    = 64;
  localparam int DEPTH = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic [3:0]           decim_log2 = '0;
  logic                 avg_en = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 rd_en = 1'b0;
  logic                 flush = 1'b0;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic [4:0]           fifo_count;
  logic                 overflow;

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;

  solver_output_decimator #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .decim_log2(decim_log2),
    .avg_en(avg_en), .in_data(in_data), .in_valid(in_valid),
    .rd_en(rd_en), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [DW-1:0] act,
                     input logic signed [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: window as a list of samples, FIFO as a queue.
  logic signed [DW-1:0] win[$];
  logic signed [DW-1:0] fq[$];
  int                   wl;
  bit                   wa;
  bit                   pend_v;
  logic signed [DW-1:0] pend_d;
  bit                   movf;

  always @(posedge clk) begin
    logic signed [127:0] s, n, q;
    bit p;
    if (!rst_n) begin
      win.delete(); fq.delete();
      pend_v = 0; pend_d = '0; movf = 0;
    end else begin
      p = rd_en && fq.size() > 0;
      if (flush) begin
        fq.delete();
        movf = 0;
      end else begin
        if (pend_v) begin
          if (fq.size() == DEPTH && !p) movf = 1;
          else begin
            if (p) void'(fq.pop_front());
            fq.push_back(pend_d);
            p = 0;
          end
        end
        if (p) void'(fq.pop_front());
      end
      pend_v = 0;
      if (!en) win.delete();
      else if (in_valid) begin
        if (win.size() == 0) begin
          wl = int'(decim_log2);
          wa = avg_en;
        end
        win.push_back(in_data);
        if (win.size() == (1 << wl)) begin
          s = 0;
          foreach (win[i]) s = s + 128'(win[i]);
          n = 128'sd1 <<< wl;
          q = s / n;
          if (q * n != s && s < 0) q = q - 1;
          pend_d = wa ? q[DW-1:0] : in_data;
          pend_v = 1;
          win.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("out_valid", 64'(out_valid), 64'(fq.size() != 0));
      chk("fifo_count", 64'(fifo_count), 64'(fq.size()));
      chk("out_data", out_data, fq.size() != 0 ? fq[0] : '0);
      chk("overflow", 64'(overflow), 64'(movf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic signed [DW-1:0] v);
    chk(name, out_data, v);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    tick(); tick();
    go = 1'b1;
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_data", out_data, 64'sd0);

    // pass-through, 2-cycle latency to head
    en = 1'b1; decim_log2 = 4'd0; avg_en = 1'b0;
    in_valid = 1'b1; in_data = 5;  tick();
    chk("p1_empty_after_E", 64'(out_valid), 64'd0);
    in_data = -3; tick();
    chk("p1_head5", out_data, 64'sd5);
    in_data = 7;  tick();
    in_valid = 1'b0; tick();
    chk("p1_count", 64'(fifo_count), 64'd3);
    pop_expect("p1_a", 5); pop_expect("p1_b", -3); pop_expect("p1_c", 7);

    // averaging, floor rounding
    decim_log2 = 4'd2; avg_en = 1'b1;
    send(4); send(8); send(-2); send(3); tick(); tick();
    chk("avg_cnt", 64'(fifo_count), 64'd1);
    pop_expect("avg_pos", 3);
    send(-1); send(-1); send(-1); send(-2); tick(); tick();
    pop_expect("avg_neg", -2);

    // last-sample mode, mid-window parameter change
    decim_log2 = 4'd3; avg_en = 1'b0;
    for (int i = 1; i <= 4; i++) send(i);
    decim_log2 = 4'd1;
    for (int i = 5; i <= 8; i++) send(i);
    tick(); tick();
    chk("last_cnt", 64'(fifo_count), 64'd1);
    pop_expect("last_8", 8);
    send(10); send(11); tick(); tick();
    chk("len2_cnt", 64'(fifo_count), 64'd1);
    pop_expect("len2", 11);

    // overflow and write+pop when full across wrap
    decim_log2 = 4'd0;
    for (int i = 0; i < 17; i++) send(100 + i);
    tick(); tick();
    chk("ovf_cnt", 64'(fifo_count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head", out_data, 64'sd100);
    send(200);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("wp_cnt", 64'(fifo_count), 64'd16);
    chk("wp_ovf", 64'(overflow), 64'd1);
    for (int i = 1; i < 16; i++) pop_expect("wrap_seq", 100 + i);
    pop_expect("wrap_last", 200);

    // en drop discards partial window
    decim_log2 = 4'd2; avg_en = 1'b1;
    send(1000); send(1000);
    en = 1'b0; tick(); en = 1'b1;
    send(4); send(8); send(12); send(16); tick(); tick();
    chk("endrop_cnt", 64'(fifo_count), 64'd1);
    chk("endrop_mean", out_data, 64'sd10);
    decim_log2 = 4'd0; avg_en = 1'b0;
    send(1); send(2); send(3); tick(); tick();
    chk("pre_flush_cnt", 64'(fifo_count), 64'd4);
    chk("pre_flush_ovf", 64'(overflow), 64'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_cnt", 64'(fifo_count), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);

    // write coincident with flush is dropped
    send(7);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_wr_cnt", 64'(fifo_count), 64'd0);

    // rd_en on empty alongside a write
    rd_en = 1'b1; send(9); tick(); rd_en = 1'b0;
    chk("rd_empty_cnt", 64'(fifo_count), 64'd1);
    chk("rd_empty_head", out_data, 64'sd9);
    send(21); tick(); tick();

    // reset mid-window and mid-pipeline
    decim_log2 = 4'd2; avg_en = 1'b1;
    send(50);
    in_valid = 1'b1; in_data = 60;
    decim_log2 = 4'd0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; in_valid = 1'b0;
    chk("rr_valid", 64'(out_valid), 64'd0);
    chk("rr_count", 64'(fifo_count), 64'd0);
    chk("rr_ovf", 64'(overflow), 64'd0);
    chk("rr_data", out_data, 64'sd0);
    tick(); tick();
    chk("rr_no_pend", 64'(fifo_count), 64'd0);
    decim_log2 = 4'd2;
    send(4); send(4); send(4); send(4); tick(); tick();
    chk("rr_fresh", out_data, 64'sd4);
    pop_expect("rr_pop", 4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
